// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory-cycle sequencer and related blocks.
// Holds the sequencer state encoding, the default privileged and I/O address
// boundaries, and the encodings for the access region and the fault cause.
package lc3_pkg;

  // Sequencer states, 3-bit encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHK    = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  // Address map defaults: 0..SYS_TOP is system-only, IO_BASE..top is I/O
  localparam logic [15:0] SYS_TOP_DEF = 16'h2FFF;
  localparam logic [15:0] IO_BASE_DEF = 16'hFE00;

  // Region selected for the current access
  localparam logic REGION_MEM = 1'b0;
  localparam logic REGION_IO  = 1'b1;

  // Why the sequencer ended up in FAULT
  localparam logic CAUSE_ACV = 1'b0;
  localparam logic CAUSE_TO  = 1'b1;

endpackage

// File: rtl/lc3_acv_chk.sv
// Combinational privilege / region decode for LC-3 accesses.
// Ports:
//   addr      in  access address
//   priv      in  1 = user mode (PSR[15])
//   violation out user-mode access to the system area or the I/O region
//   io_sel    out address lies in the I/O region
module lc3_acv_chk
  import lc3_pkg::*;
#(
  parameter int              ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SYS_TOP = SYS_TOP_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              priv,
  output logic              violation,
  output logic              io_sel
);

  logic sys_area;

  always_comb begin
    sys_area  = (addr <= SYS_TOP);
    io_sel    = (addr >= IO_BASE);
    violation = priv & (sys_area | io_sel);
  end

endmodule

// File: rtl/lc3_mem_seq.sv
// LC-3 memory-cycle sequencer. Takes one read/write request at a time from
// the control FSM, checks privilege, routes the access to memory or the I/O
// region, inserts memory wait states, guards the access with a timeout and
// returns a one-cycle ready / acv / err completion pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, we, priv       request strobe (sampled in IDLE), write, user mode
//   addr, wdata         access address and write data
//   cfg_wait            memory wait states, latched with req
//   rdata               read data, valid while ready=1
//   ready, acv, err     completion / access-violation / timeout pulses
//   mem_cs, mem_we      memory select and write enable (mem_we shared by I/O)
//   mem_addr, mem_wdata bus address and write data (shared by I/O)
//   mem_rdata, mem_ack  memory read data and acknowledge
//   io_cs               I/O select
//   io_rdata, io_ack    I/O read data and acknowledge
module lc3_mem_seq
  import lc3_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                WAIT_W  = 4,
  parameter int                TO_W    = 8,
  parameter logic [ADDR_W-1:0] SYS_TOP = SYS_TOP_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              priv,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              acv,
  output logic              err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              io_cs,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack
);

  // Timeout fires when the counter would step onto all-ones, i.e. after
  // 2^TO_W-1 ACCESS cycles without an honoured ack.
  localparam logic [TO_W-1:0] TO_ONES = '1;
  localparam logic [TO_W-1:0] TO_LAST = TO_ONES - TO_W'(1);

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic              priv_q, priv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0]   tocnt_q, tocnt_d;
  logic              io_q, io_d;
  logic              cause_q, cause_d;

  logic              viol;
  logic              io_sel;
  logic              ack_ok;

  lc3_acv_chk #(
    .ADDR_W  (ADDR_W),
    .SYS_TOP (SYS_TOP),
    .IO_BASE (IO_BASE)
  ) u_acv_chk (
    .addr      (addr_q),
    .priv      (priv_q),
    .violation (viol),
    .io_sel    (io_sel)
  );

  // State and latched-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      priv_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      tocnt_q <= '0;
      io_q    <= REGION_MEM;
      cause_q <= CAUSE_ACV;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      priv_q  <= priv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      tocnt_q <= tocnt_d;
      io_q    <= io_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    priv_d  = priv_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wcnt_d  = wcnt_q;
    tocnt_d = tocnt_q;
    io_d    = io_q;
    cause_d = cause_q;
    ack_ok  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          priv_d  = priv;
          addr_d  = addr;
          wdata_d = wdata;
          wcnt_d  = cfg_wait;
          io_d    = REGION_MEM;
          cause_d = CAUSE_ACV;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        tocnt_d = '0;
        if (viol) begin
          cause_d = CAUSE_ACV;
          state_d = ST_FAULT;
        end else begin
          io_d    = io_sel;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // I/O ignores wait states; memory ack counts only once waits expire
        if (io_q == REGION_IO) begin
          ack_ok = io_ack;
        end else begin
          ack_ok = mem_ack && (wcnt_q == '0);
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WAIT_W'(1);
          end
        end
        tocnt_d = tocnt_q + TO_W'(1);
        // An ack in the same cycle as the timeout takes priority
        if (ack_ok) begin
          if (!we_q) begin
            rdata_d = (io_q == REGION_IO) ? io_rdata : mem_rdata;
          end
          state_d = ST_DONE;
        end else if (tocnt_q == TO_LAST) begin
          cause_d = CAUSE_TO;
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    mem_cs    = (state_q == ST_ACCESS) && (io_q == REGION_MEM);
    io_cs     = (state_q == ST_ACCESS) && (io_q == REGION_IO);
    mem_we    = (state_q == ST_ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    ready     = (state_q == ST_DONE);
    acv       = (state_q == ST_FAULT) && (cause_q == CAUSE_ACV);
    err       = (state_q == ST_FAULT) && (cause_q == CAUSE_TO);
  end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Directed testbench for lc3_mem_seq. Cycle 0 is the cycle in which req is
// presented in IDLE; outputs are sampled 1 time unit after each rising edge.
module tb_lc3_mem_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic        priv;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [3:0]  cfg_wait;
  logic [15:0] rdata;
  logic        ready, acv, err;
  logic        mem_cs, mem_we, io_cs;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, io_rdata;
  logic        mem_ack, io_ack;

  int n_checks = 0;
  int n_fail   = 0;

  wire [5:0] flags = {mem_cs, io_cs, mem_we, ready, acv, err};

  always #5 clk = ~clk;

  lc3_mem_seq #(
    .ADDR_W (16),
    .DATA_W (16),
    .WAIT_W (4),
    .TO_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .priv      (priv),
    .addr      (addr),
    .wdata     (wdata),
    .cfg_wait  (cfg_wait),
    .rdata     (rdata),
    .ready     (ready),
    .acv       (acv),
    .err       (err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .io_cs     (io_cs),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE for one cycle; returns during cycle 1
  task automatic start_req(input logic w, input logic p, input logic [15:0] a,
                           input logic [15:0] d, input logic [3:0] cw);
    we = w; priv = p; addr = a; wdata = d; cfg_wait = cw; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", flags);
    end
    n_checks++;
    if ({rdata, mem_addr, mem_wdata} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_mem();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    start_req(1'b0, 1'b0, 16'h3000, 16'h0000, 4'd0);
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL rd_c1_flags: got %b want 000000", flags);
    end
    tick();
    n_checks++;
    if (flags !== 6'b100000 || mem_addr !== 16'h3000) begin
      n_fail++; $display("FAIL rd_c2: got flags %b addr %h want 100000 3000", flags, mem_addr);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_c3: got flags %b rdata %h want 000100 beef", flags, rdata);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL rd_c4_idle: got %b want 000000", flags);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_write_wait();
    mem_ack = 1'b0;
    start_req(1'b1, 1'b0, 16'h4000, 16'h1234, 4'd3);
    tick();
    mem_ack = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      n_checks++;
      if (flags !== 6'b101000 || mem_wdata !== 16'h1234 || mem_addr !== 16'h4000) begin
        n_fail++;
        $display("FAIL wr_c%0d: got flags %b wdata %h addr %h want 101000 1234 4000",
                 c, flags, mem_wdata, mem_addr);
      end
      tick();
    end
    // rdata keeps the previous read value across a write
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_c6: got flags %b rdata %h want 000100 beef", flags, rdata);
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_acv();
    logic [15:0] a_tab [6] = '{16'h0200, 16'hFE04, 16'h2FFF, 16'h3000, 16'hFDFF, 16'hFE00};
    logic        w_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        v_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0]  exp2, exp3;
    mem_ack = 1'b1; io_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp2 = v_tab[i] ? 6'b000010 : {1'b1, 1'b0, w_tab[i], 3'b000};
      exp3 = v_tab[i] ? 6'b000000 : 6'b000100;
      start_req(w_tab[i], 1'b1, a_tab[i], 16'h5555, 4'd0);
      tick();
      n_checks++;
      if (flags !== exp2) begin
        n_fail++; $display("FAIL priv_c2 addr %h: got %b want %b", a_tab[i], flags, exp2);
      end
      tick();
      n_checks++;
      if (flags !== exp3) begin
        n_fail++; $display("FAIL priv_c3 addr %h: got %b want %b", a_tab[i], flags, exp3);
      end
      tick();
    end
    mem_ack = 1'b0; io_ack = 1'b0;
  endtask

  task automatic test_io();
    io_ack = 1'b1; io_rdata = 16'h8000; mem_ack = 1'b0;
    start_req(1'b0, 1'b0, 16'hFE04, 16'h0000, 4'd7);
    tick();
    n_checks++;
    if (flags !== 6'b010000 || mem_addr !== 16'hFE04) begin
      n_fail++; $display("FAIL io_c2: got flags %b addr %h want 010000 fe04", flags, mem_addr);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'h8000) begin
      n_fail++; $display("FAIL io_c3: got flags %b rdata %h want 000100 8000", flags, rdata);
    end
    io_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    mem_ack = 1'b0;
    start_req(1'b0, 1'b0, 16'h5000, 16'h0000, 4'd0);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (flags !== 6'b100000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL to_access: %0d of 15 cycles not 100000, want 0", bad);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000001) begin
      n_fail++; $display("FAIL to_err: got %b want 000001", flags);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL to_idle: got %b want 000000", flags);
    end
    // Ack arrives on the 15th ACCESS cycle and beats the timeout
    start_req(1'b0, 1'b0, 16'h5000, 16'h0000, 4'd0);
    for (int k = 0; k < 14; k++) tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    n_checks++;
    if (flags !== 6'b100000) begin
      n_fail++; $display("FAIL to_late_c16: got %b want 100000", flags);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'hA5A5) begin
      n_fail++; $display("FAIL to_late_ready: got flags %b rdata %h want 000100 a5a5", flags, rdata);
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    start_req(1'b1, 1'b0, 16'h3000, 16'h7777, 4'd5);
    tick();
    tick();
    n_checks++;
    if (flags !== 6'b101000) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b want 101000", flags);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b000000 || {rdata, mem_addr, mem_wdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got flags %b data %h want 000000 0", flags,
               {rdata, mem_addr, mem_wdata});
    end
    tick();
    rst_n = 1'b1;
    tick();
    mem_rdata = 16'h1357;
    start_req(1'b0, 1'b0, 16'h3000, 16'h0000, 4'd0);
    tick();
    n_checks++;
    if (flags !== 6'b100000) begin
      n_fail++; $display("FAIL rst_mid_after_c2: got %b want 100000", flags);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'h1357) begin
      n_fail++; $display("FAIL rst_mid_after_c3: got flags %b rdata %h want 000100 1357", flags, rdata);
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    we = 1'b0; priv = 1'b0; addr = 16'h3000; cfg_wait = 4'd0; req = 1'b1;
    tick();
    addr = 16'h3100;  // ignored outside IDLE
    tick();
    n_checks++;
    if (flags !== 6'b100000 || mem_addr !== 16'h3000) begin
      n_fail++; $display("FAIL b2b_c2: got flags %b addr %h want 100000 3000", flags, mem_addr);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL b2b_c3: got flags %b rdata %h want 000100 beef", flags, rdata);
    end
    mem_rdata = 16'h2222;
    tick();
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL b2b_c4: got %b want 000000", flags);
    end
    tick();
    tick();
    n_checks++;
    if (flags !== 6'b100000 || mem_addr !== 16'h3100) begin
      n_fail++; $display("FAIL b2b_c6: got flags %b addr %h want 100000 3100", flags, mem_addr);
    end
    tick();
    n_checks++;
    if (flags !== 6'b000100 || rdata !== 16'h2222) begin
      n_fail++; $display("FAIL b2b_c7: got flags %b rdata %h want 000100 2222", flags, rdata);
    end
    req = 1'b0;
    tick();
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++; $display("FAIL b2b_c8: got %b want 000000", flags);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; priv = 1'b0; addr = '0; wdata = '0;
    cfg_wait = '0; mem_rdata = '0; mem_ack = 1'b0; io_rdata = '0; io_ack = 1'b0;
    test_reset();
    test_read_mem();
    test_write_wait();
    test_acv();
    test_io();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
